// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: 8-bit MISR compaction of CUT responses, cycle count,
// golden-signature compare with sticky pass/fail. Optional macro BRA_CNT_CHECK_EN
// also requires the compacted-cycle count to equal EXP_CYCLES for a pass.
module bist_resp_analyzer #(
  parameter int unsigned     SIG_W      = 8,
  parameter logic [SIG_W-1:0] POLY      = 8'h1D,
  parameter logic [SIG_W-1:0] SEED      = 8'h00,
  parameter logic [SIG_W-1:0] GOLDEN    = 8'h00,
  parameter logic [15:0]      EXP_CYCLES = 16'd0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             capture_en,
  input  logic             finish,
  input  logic             e0,
  input  logic             e1,
  input  logic             e2,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      cycles,
  output logic             busy,
  output logic             done,
  output logic             pass_fail
);

  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, DONE} state_t;

  state_t           state_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [15:0]      cyc_q;
  logic [15:0]      cyc_d;
  logic             busy_q;
  logic             done_q;
  logic             pf_q;
  logic             match_d;

  always_comb begin
    sig_d = {sig_q[SIG_W-2:0], 1'b0}
          ^ (sig_q[SIG_W-1] ? POLY : '0)
          ^ {{(SIG_W-3){1'b0}}, e2, e1, e0};
    cyc_d = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
`ifdef BRA_CNT_CHECK_EN
    match_d = (sig_q == GOLDEN) && (cyc_q == EXP_CYCLES);
`else
    match_d = (sig_q == GOLDEN);
`endif
  end

`ifndef BRA_CNT_CHECK_EN
  logic unused_exp_cycles;
  assign unused_exp_cycles = ^EXP_CYCLES;
`endif

  // start overrides every state, including the finish of the same cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pf_q    <= 1'b0;
    end else if (start) begin
      state_q <= COMPACT;
      sig_q   <= SEED;
      cyc_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pf_q    <= 1'b0;
    end else begin
      case (state_q)
        COMPACT: begin
          if (capture_en) begin
            sig_q <= sig_d;
            cyc_q <= cyc_d;
          end
          if (finish) begin
            state_q <= COMPARE;
            busy_q  <= 1'b0;
          end
        end
        COMPARE: begin
          pf_q    <= match_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        IDLE, DONE: ;
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sig       = sig_q;
  assign cycles    = cyc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_fail = pf_q;

endmodule
